act_pingpong_buff: RTL and testbench
====================================

# act_pingpong_buff

Double-buffered per-row activation buffer between the activation loader and the PE array rows. Each of `nb_pe_row` rows owns two banks (ping/pong) of `mem_depth` compressed-activation words. The loader fills one bank set while the array drains the other, and a fill/drain handshake swaps ownership. Reads are registered with a fixed 2-cycle latency and a per-row valid, so the array can stall the buffer without losing data.

## Interface
Parameters:
- `nb_pe_row`, 16, number of rows (independent bank pairs).
- `compressed_act_width`, 17, word width (16-bit activation plus 1 flag bit).
- `mem_depth`, 768, words per bank.
- `addr_width`, `$clog2(mem_depth)`, address width.

Ports:
- `clk`, in, 1, single clock; all logic on rising edge.
- `rst_n`, in, 1, asynchronous active-low reset.
- `wr_en`, in, `nb_pe_row`, per-row active-high write strobe.
- `wr_addr`, in, `nb_pe_row`×`addr_width`, per-row write address.
- `wr_data`, in, `nb_pe_row`×`compressed_act_width`, per-row write data.
- `fill_done`, in, 1, pulse: commit the current fill bank set.
- `fill_ready`, out, 1, the fill bank set is free and accepting writes.
- `rd_en`, in, `nb_pe_row`, per-row active-high read strobe.
- `rd_addr`, in, `nb_pe_row`×`addr_width`, per-row read address.
- `drain_done`, in, 1, pulse: release the current drain bank set.
- `drain_valid`, out, 1, the drain bank set holds committed data.
- `act_out`, out, `nb_pe_row`×`compressed_act_width`, registered read data.
- `act_out_valid`, out, `nb_pe_row`, per-row read-data valid.
- `occupancy`, out, 2, number of committed bank sets (0..2).
- `err_wr_drop`, out, 1, sticky flag; present only with the macro.
- `err_rd_empty`, out, 1, sticky flag; present only with the macro.

## Operation
- **Bank state.** Each bank set b∈{0,1} is FREE or FULL. There is a write pointer `wp` and a read pointer `rp`. Reset: both sets FREE, `wp=rp=0`.
- **Status outputs.**
  - `fill_ready = (state[wp]==FREE)`.
  - `drain_valid = (state[rp]==FULL)`.
  - `occupancy` = count of FULL sets.
- **Writes.** A write to row i lands in bank `wp` only when `fill_ready` is high and `wr_addr[i] < mem_depth`. Otherwise it is dropped and memory is unchanged.
- **`fill_done`.**
  - With `fill_ready`: `state[wp]←FULL`, `wp` toggles.
  - Without `fill_ready`: ignored.
  - Writes in the same cycle as `fill_done` land in the old `wp` set.
- **Reads.** `rd_en[i]` with `drain_valid` reads bank `rp`, row i.
  - Read without `drain_valid`, or with `rd_addr[i] >= mem_depth`: the read still produces `act_out_valid[i]`, with data forced to 0.
- **`drain_done`.**
  - With `drain_valid`: `state[rp]←FREE`, `rp` toggles.
  - Without `drain_valid`: ignored.
  - A read in the same cycle as `drain_done` uses the old `rp`, and its data returns normally.
- **Simultaneous `fill_done` and `drain_done`.** Both apply in the same cycle. `occupancy` is unchanged. The fill state update and the drain state update are to different sets except when `wp==rp`; in that case only one of the two can be accepted (a set cannot be both FREE and FULL).
- **Output hold.** `act_out[i]` holds its last value when no read returns. `act_out_valid[i]` is a 1-cycle pulse per read.
- **Reset mid-operation.** Contents of memory are not cleared. All state, pointers, outputs and flags return to reset values.

## Timing
- **Reset values.**
  - `act_out=0`, `act_out_valid=0`, `occupancy=0`.
  - `fill_ready=1`, `drain_valid=0`.
  - `err_*=0`.
- **Read latency.** `rd_en` sampled at edge t → array read at edge t+1 → `act_out`/`act_out_valid` registered at edge t+2. Full throughput: one read per row per cycle.
- **Commit timing.**
  - `fill_done` sampled at edge t: `drain_valid` can rise after edge t, so the first legal read is issued in cycle t+1.
  - `drain_done` sampled at edge t: `fill_ready` for that set rises after edge t.
- **Write visibility.** A write at edge t is readable by a read issued after commit. Read-during-write to the same set is impossible by construction.

## Configuration
- **`ACT_BUFF_ERR_FLAG_EN` defined:**
  - `err_wr_drop` sets on any `wr_en[i]` dropped, whether because `fill_ready` is low or the address is out of range.
  - `err_rd_empty` sets on any `rd_en[i]` while `drain_valid` is low or the address is out of range.
  - Both flags are sticky until `rst_n`.
- **Not defined:** both ports are absent and no flag logic is built.

## Test plan
- **Reset.** Assert `rst_n=0` mid-stream → `fill_ready=1`, `drain_valid=0`, `occupancy=0`, `act_out=0`, `act_out_valid=0`.
- **Ping-pong fill/drain.**
  - Fill row 3 addr 0..767 with data=addr, then `fill_done` → `occupancy=1`, `drain_valid=1`.
  - Read addr 5 → `act_out[3]=5` with valid exactly 2 cycles after `rd_en`.
- **Back-pressure.**
  - Issue two fills plus two `fill_done` with no drain → `occupancy=2`, `fill_ready=0`.
  - Issue a third write with value 0x1ABCD → dropped; a later drain of that address shows the prior data. With the macro, `err_wr_drop=1`.
- **Simultaneous commit.** `occupancy=1`, assert `fill_done` and `drain_done` in the same cycle → `occupancy` stays 1, both `wp` and `rp` toggle, and the new drain set returns the second fill's data.
- **Empty read.** Issue `rd_en[0]` with `drain_valid=0` → `act_out_valid[0]` pulses at t+2 with `act_out[0]=0`. With the macro, `err_rd_empty=1`.
- **Out-of-range address.** Write then read addr 800 with `mem_depth=768` → write dropped, read returns 0, other addresses unchanged.

Source files
------------

// File: rtl/act_pingpong_buff.sv
// act_pingpong_buff
// Double-buffered per-row activation buffer. Every PE row has two banks
// (ping/pong). The loader fills the bank set at wp while the PE array
// drains the bank set at rp. fill_done and drain_done swap ownership.
// Each read strobe gives a registered result two cycles later, together
// with a one-cycle per-row valid pulse.
// Optional build macro: ACT_BUFF_ERR_FLAG_EN adds the sticky error flags
// err_wr_drop and err_rd_empty.
module act_pingpong_buff #(
    parameter int nb_pe_row            = 16,
    parameter int compressed_act_width = 17,
    parameter int mem_depth            = 768,
    parameter int addr_width           = $clog2(mem_depth)
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic [nb_pe_row-1:0]                                wr_en,
    input  logic [nb_pe_row-1:0][addr_width-1:0]                wr_addr,
    input  logic [nb_pe_row-1:0][compressed_act_width-1:0]      wr_data,
    input  logic                                                fill_done,
    output logic                                                fill_ready,
    input  logic [nb_pe_row-1:0]                                rd_en,
    input  logic [nb_pe_row-1:0][addr_width-1:0]                rd_addr,
    input  logic                                                drain_done,
    output logic                                                drain_valid,
    output logic [nb_pe_row-1:0][compressed_act_width-1:0]      act_out,
    output logic [nb_pe_row-1:0]                                act_out_valid,
    output logic [1:0]                                          occupancy
`ifdef ACT_BUFF_ERR_FLAG_EN
    ,
    output logic                                                err_wr_drop,
    output logic                                                err_rd_empty
`endif
);

    // Both banks of a row share one array: bank 0 at [0, mem_depth) and
    // bank 1 at [mem_depth, 2*mem_depth).
    localparam int IDX_W = $clog2(2 * mem_depth);
    localparam logic [addr_width:0] DEPTH_CMP = (addr_width + 1)'(mem_depth);

    logic [1:0]           full_reg, full_next;
    logic                 wp_reg, wp_next;
    logic                 rp_reg, rp_next;
    logic                 fill_acc, drain_acc;
    logic [nb_pe_row-1:0] wr_ok_vec;
    logic [nb_pe_row-1:0] rd_ok_vec;

    assign fill_ready  = ~full_reg[wp_reg];
    assign drain_valid = full_reg[rp_reg];
    assign occupancy   = 2'(full_reg[0]) + 2'(full_reg[1]);

    // Commit and release handshakes. When wp==rp, a set is either FREE or
    // FULL, so at most one of the two handshakes can be accepted.
    always_comb begin
        full_next = full_reg;
        wp_next   = wp_reg;
        rp_next   = rp_reg;
        fill_acc  = fill_done & fill_ready;
        drain_acc = drain_done & drain_valid;
        if (fill_acc) begin
            full_next[wp_reg] = 1'b1;
            wp_next           = ~wp_reg;
        end
        if (drain_acc) begin
            full_next[rp_reg] = 1'b0;
            rp_next           = ~rp_reg;
        end
    end

    // Bank ownership state and the fill/drain pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg <= 2'b00;
            wp_reg   <= 1'b0;
            rp_reg   <= 1'b0;
        end else begin
            full_reg <= full_next;
            wp_reg   <= wp_next;
            rp_reg   <= rp_next;
        end
    end

    for (genvar gi = 0; gi < nb_pe_row; gi++) begin : g_row
        logic [compressed_act_width-1:0] mem [0:2*mem_depth-1];
        logic [IDX_W-1:0]                wr_idx;
        logic [IDX_W-1:0]                rd_idx;
        logic [IDX_W-1:0]                rd_idx1_reg;
        logic                            rd_v1_reg, rd_ok1_reg;
        logic                            rd_v2_reg, rd_ok2_reg;
        logic [compressed_act_width-1:0] rd_data2_reg;
        logic [compressed_act_width-1:0] act_reg;
        logic                            act_v_reg;

        assign wr_ok_vec[gi] = wr_en[gi] & fill_ready & ({1'b0, wr_addr[gi]} < DEPTH_CMP);
        assign rd_ok_vec[gi] = drain_valid & ({1'b0, rd_addr[gi]} < DEPTH_CMP);

        assign wr_idx = wp_reg ? (IDX_W'(wr_addr[gi]) + IDX_W'(mem_depth))
                               : IDX_W'(wr_addr[gi]);
        assign rd_idx = rp_reg ? (IDX_W'(rd_addr[gi]) + IDX_W'(mem_depth))
                               : IDX_W'(rd_addr[gi]);

        // Loader write port. Memory contents survive reset.
        always_ff @(posedge clk) begin
            if (wr_ok_vec[gi]) begin
                mem[wr_idx] <= wr_data[gi];
            end
        end

        // Registered RAM read. The address was captured one cycle earlier.
        always_ff @(posedge clk) begin
            rd_data2_reg <= mem[rd_idx1_reg];
        end

        // Read pipeline control. A rejected read still returns a valid
        // pulse, with its data forced to zero.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_v1_reg   <= 1'b0;
                rd_ok1_reg  <= 1'b0;
                rd_idx1_reg <= '0;
                rd_v2_reg   <= 1'b0;
                rd_ok2_reg  <= 1'b0;
            end else begin
                rd_v1_reg   <= rd_en[gi];
                rd_ok1_reg  <= rd_en[gi] & rd_ok_vec[gi];
                rd_idx1_reg <= rd_idx;
                rd_v2_reg   <= rd_v1_reg;
                rd_ok2_reg  <= rd_ok1_reg;
            end
        end

        // Output register: it holds its value between reads, and valid is a
        // one-cycle pulse for each read.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                act_reg   <= '0;
                act_v_reg <= 1'b0;
            end else begin
                act_v_reg <= rd_v2_reg;
                if (rd_v2_reg) begin
                    act_reg <= rd_ok2_reg ? rd_data2_reg : '0;
                end
            end
        end

        assign act_out[gi]       = act_reg;
        assign act_out_valid[gi] = act_v_reg;
    end

`ifdef ACT_BUFF_ERR_FLAG_EN
    logic err_wr_drop_reg;
    logic err_rd_empty_reg;

    // Sticky error flags. They are cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_wr_drop_reg  <= 1'b0;
            err_rd_empty_reg <= 1'b0;
        end else begin
            if (|(wr_en & ~wr_ok_vec)) begin
                err_wr_drop_reg <= 1'b1;
            end
            if (|(rd_en & ~rd_ok_vec)) begin
                err_rd_empty_reg <= 1'b1;
            end
        end
    end

    assign err_wr_drop  = err_wr_drop_reg;
    assign err_rd_empty = err_rd_empty_reg;
`endif

endmodule

// File: tb/tb_act_pingpong_buff.sv
// tb_act_pingpong_buff
// Directed, self-checking bench for act_pingpong_buff. Each read pushes its
// expected row, data and arrival cycle to a scoreboard queue. A monitor
// pops an entry for every act_out_valid pulse and compares it.
module tb_act_pingpong_buff;
    localparam int NR = 16;
    localparam int W  = 17;
    localparam int D  = 768;
    localparam int AW = 10;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NR-1:0]          wr_en;
    logic [NR-1:0][AW-1:0]  wr_addr;
    logic [NR-1:0][W-1:0]   wr_data;
    logic                   fill_done;
    logic                   fill_ready;
    logic [NR-1:0]          rd_en;
    logic [NR-1:0][AW-1:0]  rd_addr;
    logic                   drain_done;
    logic                   drain_valid;
    logic [NR-1:0][W-1:0]   act_out;
    logic [NR-1:0]          act_out_valid;
    logic [1:0]             occupancy;
`ifdef ACT_BUFF_ERR_FLAG_EN
    logic                   err_wr_drop;
    logic                   err_rd_empty;
`endif

    act_pingpong_buff #(
        .nb_pe_row(NR), .compressed_act_width(W), .mem_depth(D), .addr_width(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .fill_done(fill_done), .fill_ready(fill_ready),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .drain_done(drain_done), .drain_valid(drain_valid),
        .act_out(act_out), .act_out_valid(act_out_valid),
        .occupancy(occupancy)
`ifdef ACT_BUFF_ERR_FLAG_EN
        , .err_wr_drop(err_wr_drop), .err_rd_empty(err_rd_empty)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          row;
        logic [W-1:0] data;
        int          due;
    } exp_t;
    exp_t q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Fill pattern. Row 3 of set 0 holds data equal to its address.
    function automatic logic [W-1:0] fv(input int set, input int row, input int a);
        logic [31:0] v;
        if (set == 0 && row == 3) v = a;
        else if (set == 0)        v = (row << 10) | a;
        else                      v = 32'h10000 | (row << 10) | a;
        return v[W-1:0];
    endfunction

    // Scoreboard monitor. It samples on the falling edge, away from the
    // active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int r = 0; r < NR; r++) begin
                if (act_out_valid[r]) begin
                    if (q.size() == 0) begin
                        check("spurious_valid", 32'(act_out_valid[r]), 32'd0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        $display("[TB] read row=%0d data=%0h exp=%0h cyc=%0d due=%0d",
                                 r, act_out[r], e.data, cyc, e.due);
                        check("rd_row", r, e.row);
                        check("rd_data", 32'(act_out[r]), 32'(e.data));
                        check("rd_latency", cyc, e.due);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_read(input int row, input int addr, input logic [W-1:0] exp_d);
        exp_t e;
        rd_en          = '0;
        rd_en[row]     = 1'b1;
        rd_addr[row]   = AW'(addr);
        e.row = row; e.data = exp_d; e.due = cyc + 3;
        q.push_back(e);
        tick();
        rd_en = '0;
    endtask

    task automatic fill(input int set);
        for (int a = 0; a < D; a++) begin
            wr_en = '1;
            for (int r = 0; r < NR; r++) begin
                wr_addr[r] = AW'(a);
                wr_data[r] = fv(set, r, a);
            end
            // The commit shares a cycle with the last write; that write
            // must still land in the set being committed.
            fill_done = (a == D - 1);
            tick();
        end
        wr_en     = '0;
        fill_done = 1'b0;
        $display("[TB] fill set=%0d committed occ=%0d", set, occupancy);
    endtask

    task automatic check_status(input string tag, input int occ, input bit fr, input bit dv);
        check({tag, "_occ"}, 32'(occupancy), occ);
        check({tag, "_fill_ready"}, 32'(fill_ready), 32'(fr));
        check({tag, "_drain_valid"}, 32'(drain_valid), 32'(dv));
    endtask

    initial begin
        rst_n = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; fill_done = 1'b0;
        rd_en = '0; rd_addr = '0; drain_done = 1'b0;
        repeat (3) tick();
        check_status("reset", 0, 1'b1, 1'b0);
        check("reset_act_out", 32'(act_out[3]), 32'd0);
        check("reset_valid", 32'(act_out_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        // Read with no committed set: valid pulse, zero data.
        do_read(0, 5, '0);
        repeat (3) tick();
`ifdef ACT_BUFF_ERR_FLAG_EN
        check("err_rd_empty_set", 32'(err_rd_empty), 32'd1);
        check("err_wr_drop_clear", 32'(err_wr_drop), 32'd0);
`endif

        // First fill goes to bank 0.
        fill(0);
        check_status("fill0", 1, 1'b1, 1'b1);
        do_read(3, 5, 17'd5);
        do_read(3, 767, 17'd767);
        do_read(3, 0, 17'd0);
        do_read(7, 100, fv(0, 7, 100));
        do_read(0, 800, '0);
        repeat (4) tick();

        // Second fill goes to bank 1 and leaves the buffer full.
        fill(1);
        check_status("full", 2, 1'b0, 1'b1);
        fill_done = 1'b1; tick(); fill_done = 1'b0;
        check("fill_done_ignored_occ", 32'(occupancy), 32'd2);

        // A write while full is dropped.
        wr_en[3] = 1'b1; wr_addr[3] = AW'(5); wr_data[3] = 17'h1ABCD;
        tick();
        wr_en = '0;
`ifdef ACT_BUFF_ERR_FLAG_EN
        check("err_wr_drop_set", 32'(err_wr_drop), 32'd1);
`endif
        do_read(3, 5, 17'd5);

        // A read issued with drain_done still uses the old set.
        drain_done = 1'b1;
        do_read(3, 6, 17'd6);
        drain_done = 1'b0;
        check_status("drain0", 1, 1'b1, 1'b1);

        // An out-of-range write into free bank 0 must not disturb bank 1.
        wr_en[3] = 1'b1; wr_addr[3] = AW'(800); wr_data[3] = 17'h1ABCD;
        tick();
        wr_en = '0;
        do_read(3, 32, fv(1, 3, 32));
        do_read(3, 5, fv(1, 3, 5));
        repeat (4) tick();

        // Partial refill of bank 0, then fill_done and drain_done together.
        wr_en[3] = 1'b1; wr_addr[3] = AW'(5); wr_data[3] = 17'h0C0DE;
        tick();
        wr_en = '0;
        fill_done = 1'b1; drain_done = 1'b1;
        tick();
        fill_done = 1'b0; drain_done = 1'b0;
        check_status("simul", 1, 1'b1, 1'b1);
        do_read(3, 5, 17'h0C0DE);
        do_read(3, 800, '0);
        do_read(3, 6, 17'd6);
        repeat (4) tick();

        // Asynchronous reset mid-operation; memory contents are kept.
        #2 rst_n = 1'b0;
        #1;
        check_status("midrst", 0, 1'b1, 1'b0);
        check("midrst_act_out", 32'(act_out[3]), 32'd0);
        check("midrst_valid", 32'(act_out_valid), 32'd0);
`ifdef ACT_BUFF_ERR_FLAG_EN
        check("midrst_err_wr", 32'(err_wr_drop), 32'd0);
        check("midrst_err_rd", 32'(err_rd_empty), 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        fill_done = 1'b1; tick(); fill_done = 1'b0;
        check_status("recommit", 1, 1'b1, 1'b1);
        do_read(3, 5, 17'h0C0DE);
        drain_done = 1'b1; tick(); drain_done = 1'b0;
        check_status("empty", 0, 1'b1, 1'b0);
        drain_done = 1'b1; tick(); drain_done = 1'b0;
        check("drain_done_ignored_occ", 32'(occupancy), 32'd0);

        // Wait a bounded number of cycles for outstanding reads.
        for (int i = 0; i < 10 && q.size() != 0; i++) tick();
        check("scoreboard_empty", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
